sdm_rate_ctrl: RTL and testbench

Sample-rate scheduler for the sigma-delta DAC/ADC pair. Buffers incoming 16-bit audio samples from an upstream valid/ready source. Generates the modulator-rate strobe that drives the DAC and ADC valid inputs, and holds each audio sample for OSR modulator ticks (zero-order hold). Sits between the audio source and the DAC/ADC top-level wrapper; flags buffer underruns.

---
 rtl/sdm_rate_ctrl.sv | 157 +++++++++++++++
 tb/tb_sdm_rate_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_rate_ctrl.sv
// Sample-rate scheduler: buffers audio samples, emits modulator ticks and holds each sample for OSR ticks.
// Optional macro SDM_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module sdm_rate_ctrl #(
  parameter int CLK_DIV    = 8,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [15:0]                   s_data,
  output logic                          dac_valid,
  output logic [15:0]                   dac_data,
  output logic                          adc_valid,
  output logic                          sample_req,
  output logic                          underrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SDM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int RW = $clog2(OSR);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [15:0]   hold_q, hold_d;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;

  logic fifo_empty, fifo_full, push, pop, tick, last_tick, und;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign push       = s_valid && !fifo_full;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    rep_d     = rep_q;
    hold_d    = hold_q;
    pop       = 1'b0;
    tick      = 1'b0;
    last_tick = 1'b0;
    und       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        rep_d = '0;
        if (enable) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        div_d = '0;
        rep_d = '0;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        // The live enable level decides run vs drain, so re-enabling mid-drain resumes seamlessly.
        state_d   = enable ? ST_RUN : ST_DRAIN;
        tick      = (div_q == DW'(CLK_DIV - 1));
        last_tick = tick && (rep_q == RW'(OSR - 1));
        div_d     = tick ? '0 : div_q + DW'(1);
        if (tick) rep_d = last_tick ? '0 : rep_q + RW'(1);
        if (last_tick) begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            hold_d = mem_q[rd_ptr_q];
          end else begin
            und    = 1'b1;
            hold_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      rep_q    <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rep_q   <= rep_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: storage is not reset; emptying the FIFO only needs the pointers and level cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

`ifdef SDM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_cnt_q <= '0;
    end else if (und && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

  assign s_ready    = !fifo_full;
  assign dac_valid  = tick;
  assign adc_valid  = tick;
  assign dac_data   = hold_q;
  assign sample_req = pop;
  assign underrun   = und;
  assign busy       = (state_q != ST_IDLE);
  assign fifo_level = level_q;

endmodule

// File: tb/tb_sdm_rate_ctrl.sv
// Self-checking bench for sdm_rate_ctrl: expected tick/pop/underrun timing is derived arithmetically
// from the cycle offset relative to the enable cycle (t=0 idle, t=1 prime pop, tick k at t=1+CD*(k+1)).
module tb_sdm_rate_ctrl;

  localparam int CD    = 4;
  localparam int OSR   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable, s_valid;
  logic [15:0] s_data;
  logic        s_ready, dac_valid, adc_valid, sample_req, underrun, busy;
  logic [15:0] dac_data;
  logic [2:0]  fifo_level;
`ifdef SDM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] samp [8];

  // {dac_valid, adc_valid, sample_req, underrun, busy, s_ready}
  wire [5:0] flags = {dac_valid, adc_valid, sample_req, underrun, busy, s_ready};

  sdm_rate_ctrl #(.CLK_DIV(CD), .OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .dac_valid  (dac_valid),
    .dac_data   (dac_data),
    .adc_valid  (adc_valid),
    .sample_req (sample_req),
    .underrun   (underrun),
    .busy       (busy),
    .fifo_level (fifo_level)
`ifdef SDM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic push_samples(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = samp[i];
      next_cycle();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      sample_point();
      checks++;
      if (flags !== 6'b000001 || dac_data !== 16'h0 || fifo_level !== 3'd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d flags=%b data=%h lvl=%0d exp flags=000001 data=0 lvl=0",
                 c, flags, dac_data, fifo_level);
      end
      next_cycle();
    end
  endtask

  task automatic run_stream(input int n, input string name);
    int exp_level, idx, k;
    bit is_tick, last, e_sreq, e_und;
    logic [15:0] e_data;
    do_reset();
    push_samples(n);
    enable = 1'b1;
    sample_point();
    checks++;
    if (fifo_level !== 3'(n) || flags !== {5'b00000, n < DEPTH}) begin
      errors++;
      $display("FAIL %s_preload lvl=%0d flags=%b exp lvl=%0d flags=%b", name, fifo_level, flags, n,
               {5'b00000, n < DEPTH});
    end
    exp_level = n;
    for (int t = 1; t <= 1 + CD * OSR * (n + 1); t++) begin
      next_cycle();
      sample_point();
      is_tick = 1'b0; e_sreq = (t == 1); e_und = 1'b0; e_data = '0;
      if (t >= 2) begin
        is_tick = ((t - 1) % CD) == 0;
        k       = (t - 1) / CD - 1;
        idx     = k / OSR;
        last    = is_tick && (k % OSR == OSR - 1);
        e_sreq  = last && (idx + 1 < n);
        e_und   = last && !(idx + 1 < n);
        e_data  = (idx < n) ? samp[idx] : 16'h0;
      end
      checks++;
      if (flags !== {is_tick, is_tick, e_sreq, e_und, 1'b1, exp_level < DEPTH} ||
          fifo_level !== 3'(exp_level)) begin
        errors++;
        $display("FAIL %s_timing t=%0d flags=%b lvl=%0d exp flags=%b lvl=%0d", name, t, flags, fifo_level,
                 {is_tick, is_tick, e_sreq, e_und, 1'b1, exp_level < DEPTH}, exp_level);
      end
      if (is_tick) begin
        checks++;
        if (dac_data !== e_data) begin
          errors++;
          $display("FAIL %s_data t=%0d got=%h exp=%h", name, t, dac_data, e_data);
        end
      end
      if (e_sreq) exp_level--;
    end
    // Reset mid-run, between ticks: next cycle must show reset values with no tick.
    next_cycle();
    rst_n = 1'b0; enable = 1'b0;
    next_cycle();
    sample_point();
    checks++;
    if (flags !== 6'b000001 || dac_data !== 16'h0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL %s_mid_reset flags=%b data=%h lvl=%0d exp flags=000001 data=0 lvl=0", name, flags,
               dac_data, fifo_level);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_sample();
    samp[0] = 16'h1234;
    run_stream(1, "single");
  endtask

  task automatic test_three_samples();
    samp[0] = 16'h0100; samp[1] = 16'hFF00; samp[2] = 16'h7FFF;
    run_stream(3, "three");
  endtask

  task automatic test_random_streams();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) samp[i] = 16'($urandom);
      run_stream(n, "random");
    end
  endtask

  task automatic test_fifo_full();
    int k;
    do_reset();
    for (int i = 0; i < 5; i++) samp[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = samp[i];
      sample_point();
      checks++;
      if (s_ready !== (i < DEPTH) || fifo_level !== 3'((i < DEPTH) ? i : DEPTH)) begin
        errors++;
        $display("FAIL fill i=%0d rdy=%b lvl=%0d exp rdy=%b lvl=%0d", i, s_ready, fifo_level, i < DEPTH,
                 (i < DEPTH) ? i : DEPTH);
      end
      next_cycle();
    end
    enable = 1'b1;
    sample_point();
    checks++;
    if (s_ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_hold rdy=%b lvl=%0d exp rdy=0 lvl=4", s_ready, fifo_level);
    end
    next_cycle();
    sample_point();
    checks++;
    if (sample_req !== 1'b1 || s_ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_pop req=%b rdy=%b lvl=%0d exp req=1 rdy=0 lvl=4", sample_req, s_ready, fifo_level);
    end
    next_cycle();
    sample_point();
    checks++;
    if (s_ready !== 1'b1 || fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL full_after_pop rdy=%b lvl=%0d exp rdy=1 lvl=3", s_ready, fifo_level);
    end
    next_cycle();
    s_valid = 1'b0;
    sample_point();
    checks++;
    if (s_ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_refill rdy=%b lvl=%0d exp rdy=0 lvl=4", s_ready, fifo_level);
    end
    for (int t = 4; t <= 1 + CD * (4 * OSR + 1); t++) begin
      next_cycle();
      sample_point();
      if (((t - 1) % CD) == 0) begin
        k = (t - 1) / CD - 1;
        if (k % OSR == 0) begin
          checks++;
          if (dac_valid !== 1'b1 || dac_data !== samp[k / OSR]) begin
            errors++;
            $display("FAIL full_order s=%0d valid=%b data=%h exp valid=1 data=%h", k / OSR, dac_valid,
                     dac_data, samp[k / OSR]);
          end
        end
      end
    end
  endtask

  task automatic test_drain();
    bit is_tick, e_busy;
    do_reset();
    samp[0] = 16'($urandom); samp[1] = 16'($urandom);
    push_samples(2);
    enable = 1'b1;
    for (int t = 1; t <= 1 + 7 * CD; t++) begin
      next_cycle();
      if (t == 2 + 2 * CD) enable = 1'b0;
      sample_point();
      is_tick = (t > 1) && (((t - 1) % CD) == 0) && (t <= 1 + 4 * CD);
      e_busy  = (t <= 1 + 4 * CD);
      checks++;
      if (flags !== {is_tick, is_tick, t == 1, 1'b0, e_busy, 1'b1} || fifo_level !== ((t == 1) ? 3'd2 : 3'd1)) begin
        errors++;
        $display("FAIL drain t=%0d flags=%b lvl=%0d exp flags=%b lvl=%0d", t, flags, fifo_level,
                 {is_tick, is_tick, t == 1, 1'b0, e_busy, 1'b1}, (t == 1) ? 2 : 1);
      end
      if (is_tick && dac_data !== samp[0]) begin
        errors++;
        $display("FAIL drain_data t=%0d got=%h exp=%h", t, dac_data, samp[0]);
      end
    end
    // The remaining sample must survive the drain and come out on the next run.
    next_cycle();
    enable = 1'b1;
    for (int t = 1; t <= 1 + CD; t++) begin
      next_cycle();
      sample_point();
      if (t == 1) begin
        checks++;
        if (sample_req !== 1'b1) begin
          errors++;
          $display("FAIL drain_resume_pop got=%b exp=1", sample_req);
        end
      end
    end
    checks++;
    if (dac_valid !== 1'b1 || dac_data !== samp[1]) begin
      errors++;
      $display("FAIL drain_resume_data valid=%b data=%h exp valid=1 data=%h", dac_valid, dac_data, samp[1]);
    end
    enable = 1'b0;
  endtask

`ifdef SDM_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    do_reset();
    sample_point();
    checks++;
    if (underrun_cnt !== 16'h0) begin
      errors++;
      $display("FAIL ucnt_reset got=%h exp=0000", underrun_cnt);
    end
    samp[0] = 16'h5555;
    push_samples(1);
    enable = 1'b1;
    for (int t = 1; t <= 2 + 3 * CD * OSR; t++) next_cycle();
    sample_point();
    checks++;
    if (underrun_cnt !== 16'd3) begin
      errors++;
      $display("FAIL ucnt_three got=%h exp=0003", underrun_cnt);
    end
    force dut.underrun_cnt_q = 16'hFFFE;
    next_cycle();
    release dut.underrun_cnt_q;
    for (int t = 4 + 3 * CD * OSR; t <= 2 + 5 * CD * OSR; t++) next_cycle();
    sample_point();
    checks++;
    if (underrun_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL ucnt_saturate got=%h exp=ffff", underrun_cnt);
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    next_cycle();
    test_reset();
    test_single_sample();
    test_three_samples();
    test_random_streams();
    test_fifo_full();
    test_drain();
`ifdef SDM_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
